// File: rtl/vga_writer_pkg.sv
// vga_writer_pkg: writer FSM encoding, default geometry and CRC-16-CCITT constants shared by vga_line_writer
package vga_writer_pkg;
  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_REQ   = 2'd1,
    W_BURST = 2'd2,
    W_DONE  = 2'd3
  } w_state_t;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int V_ACTIVE_DEF = 768;
  localparam int LOG2_H       = $clog2(H_ACTIVE_DEF);

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One 16-bit word folded into the CRC, MSB first
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? CRC_POLY : 16'h0000);
    return c;
  endfunction
endpackage

// File: rtl/vga_line_ram.sv
// vga_line_ram: two H-word line buffers (MSB of the address selects the buffer), one write port, registered read port
module vga_line_ram
  import vga_writer_pkg::*;
#(
  parameter int AW = LOG2_H
) (
  input  logic          clk_vga,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [15:0]   wdata,
  input  logic [AW:0]   raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem_q [2**(AW+1)];
  logic [15:0] rdata_q;

  // Capture side writes one pixel per enabled cycle
  always_ff @(posedge clk_vga) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read so the burst side can pre-address the next word
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/vga_line_writer.sv
// vga_line_writer: captures RGB565 lines into ping-pong buffers and writes each completed line as one SDRAM burst
// Optional per-frame CRC-16-CCITT of captured pixels: define VGA_LINE_WRITER_CRC_EN
module vga_line_writer
  import vga_writer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 24
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_vs,
  input  logic              in_de,
  input  logic [15:0]       in_pixel,
  input  logic [ADDR_W-1:0] fb_base_addr,
  output logic              sdram_wr_req,
  input  logic              sdram_wr_grant,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [15:0]       sdram_wr_data,
  input  logic              sdram_wr_ready,
  input  logic              sdram_wr_done,
  output logic              frame_done,
  output logic              overflow,
`ifdef VGA_LINE_WRITER_CRC_EN
  output logic [15:0]       crc16,
  output logic              crc_valid,
`endif
  output logic [1:0]        debug_state
);
  localparam int LH = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE) + 1;
  localparam logic [LH:0]   H_MAX = H_ACTIVE[LH:0];
  localparam logic [YW-1:0] V_MAX = V_ACTIVE[YW-1:0];
  localparam logic [YW-1:0] V_LAST = V_MAX - 1'b1;

  logic              vs_q, de_q, acc_q, acc_d, cap_q, cap_d, wbuf_q, wbuf_d;
  logic              ovf_q, ovf_d, req_q, req_d, fd_q, fd_d;
  logic [LH:0]       x_q, x_d, rd_q, rd_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [1:0]        full_q, full_d;
  logic [LH:0]       len_q [2];
  logic [LH:0]       len_d [2];
  logic [YW-1:0]     ly_q [2];
  logic [YW-1:0]     ly_d [2];
  w_state_t          state_q, state_d;
  logic              vs_rise, de_rise, de_fall, free_now, tgt_empty, accept_now, wr_en;
  logic [LH-1:0]     ra;
  logic [15:0]       ram_q;

  // Edge detection and the line accept decision; a buffer freed this cycle counts as empty
  always_comb begin
    vs_rise    = in_vs & ~vs_q;
    de_rise    = in_de & ~de_q;
    de_fall    = ~in_de & de_q;
    free_now   = (state_q == W_BURST) & sdram_wr_done;
    tgt_empty  = ~full_q[cap_q] | (free_now & (wbuf_q == cap_q));
    accept_now = enable & (y_q < V_MAX) & tgt_empty;
    wr_en      = in_de & (de_rise ? accept_now : acc_q) & (x_q < H_MAX);
    ra         = state_q != W_BURST ? '0 : sdram_wr_ready ? LH'(rd_q + 1'b1) : rd_q[LH-1:0];
  end

  // Capture side: x/y counters, buffer fill bookkeeping, frame base latch
  always_comb begin
    acc_d  = de_rise ? accept_now : acc_q;
    ovf_d  = ovf_q | (de_rise & enable & (y_q < V_MAX) & ~tgt_empty);
    x_d    = wr_en ? x_q + 1'b1 : x_q;
    y_d    = y_q;
    cap_d  = cap_q;
    full_d = full_q;
    len_d  = len_q;
    ly_d   = ly_q;
    base_d = base_q;
    if (de_fall) begin
      x_d = '0;
      y_d = (y_q < V_MAX) ? y_q + 1'b1 : y_q;
      if (acc_q) begin
        full_d[cap_q] = 1'b1;
        len_d[cap_q]  = x_q;
        ly_d[cap_q]   = y_q;
        cap_d         = ~cap_q;
      end
    end
    if (vs_rise) begin
      x_d    = '0;
      y_d    = '0;
      base_d = fb_base_addr;
    end
    if (free_now) full_d[wbuf_q] = 1'b0;
  end

  // Writer FSM: serve buffers in capture order, one burst per line
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    fd_d    = 1'b0;
    case (state_q)
      W_IDLE: if (full_q[wbuf_q]) begin
        state_d = W_REQ;
        req_d   = 1'b1;
        addr_d  = base_q + (ADDR_W'(ly_q[wbuf_q]) << LH);
      end
      W_REQ: if (sdram_wr_grant) begin
        state_d = W_BURST;
        rd_d    = '0;
      end
      W_BURST: begin
        if (sdram_wr_ready && rd_q < H_MAX) rd_d = rd_q + 1'b1;
        if (sdram_wr_done) begin
          state_d = W_DONE;
          req_d   = 1'b0;
          wbuf_d  = ~wbuf_q;
          fd_d    = ly_q[wbuf_q] == V_LAST;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  // All capture and writer state
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      acc_q   <= 1'b0;
      cap_q   <= 1'b0;
      wbuf_q  <= 1'b0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
      fd_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rd_q    <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      full_q  <= '0;
      len_q   <= '{default: '0};
      ly_q    <= '{default: '0};
      state_q <= W_IDLE;
    end else begin
      vs_q    <= in_vs;
      de_q    <= in_de;
      acc_q   <= acc_d;
      cap_q   <= cap_d;
      wbuf_q  <= wbuf_d;
      ovf_q   <= ovf_d;
      req_q   <= req_d;
      fd_q    <= fd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rd_q    <= rd_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      len_q   <= len_d;
      ly_q    <= ly_d;
      state_q <= state_d;
    end
  end

  vga_line_ram #(.AW(LH)) u_ram (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .we      (wr_en),
    .waddr   ({cap_q, x_q[LH-1:0]}),
    .wdata   (in_pixel),
    .raddr   ({wbuf_q, ra}),
    .rdata   (ram_q)
  );

  assign sdram_wr_req  = req_q;
  assign sdram_wr_addr = addr_q;
  assign sdram_wr_data = (state_q == W_BURST && rd_q < len_q[wbuf_q]) ? ram_q : 16'h0000;
  assign frame_done    = fd_q;
  assign overflow      = ovf_q;
  assign debug_state   = state_q;

`ifdef VGA_LINE_WRITER_CRC_EN
  logic [15:0] crc_q, crc_d, crc_out_q, crc_out_d;

  // Running CRC over written pixels; snapshot when the last frame line is captured
  always_comb begin
    crc_d     = vs_rise ? CRC_INIT : wr_en ? crc16_step(crc_q, in_pixel) : crc_q;
    crc_out_d = (de_fall & acc_q & (y_q == V_LAST)) ? crc_q : crc_out_q;
  end

  // CRC state
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= CRC_INIT;
      crc_out_q <= '0;
    end else begin
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign crc16     = crc_out_q;
  assign crc_valid = fd_q;
`endif
endmodule

// File: tb/tb_vga_line_writer.sv
// tb_vga_line_writer: directed self-checking bench for vga_line_writer (small geometry H=16, V=4)
module tb_vga_line_writer;
  localparam int H  = 16;
  localparam int V  = 4;
  localparam int AW = 24;

  logic          clk_vga = 0, rst_n = 0, enable = 0, in_vs = 0, in_de = 0;
  logic [15:0]   in_pixel = 0;
  logic [AW-1:0] fb_base_addr = 0;
  logic          sdram_wr_req, sdram_wr_grant = 0, sdram_wr_ready = 0, sdram_wr_done = 0;
  logic [AW-1:0] sdram_wr_addr;
  logic [15:0]   sdram_wr_data;
  logic          frame_done, overflow;
  logic [1:0]    debug_state;
`ifdef VGA_LINE_WRITER_CRC_EN
  logic [15:0]   crc16, crc_seen;
  logic          crc_valid, crc_v;
`endif

  int checks, errors, nb, fd_cnt, hold_grant, rdy_mode, exp_n, k;
  logic [AW-1:0] b_addr [32];
  logic [15:0]   b_data [32][H];

  typedef struct { int len; bit en; bit wr; } line_t;
  line_t tbl [5];

  always #5 clk_vga = ~clk_vga;

  vga_line_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk_vga        (clk_vga),
    .rst_n          (rst_n),
    .enable         (enable),
    .in_vs          (in_vs),
    .in_de          (in_de),
    .in_pixel       (in_pixel),
    .fb_base_addr   (fb_base_addr),
    .sdram_wr_req   (sdram_wr_req),
    .sdram_wr_grant (sdram_wr_grant),
    .sdram_wr_addr  (sdram_wr_addr),
    .sdram_wr_data  (sdram_wr_data),
    .sdram_wr_ready (sdram_wr_ready),
    .sdram_wr_done  (sdram_wr_done),
    .frame_done     (frame_done),
    .overflow       (overflow),
`ifdef VGA_LINE_WRITER_CRC_EN
    .crc16          (crc16),
    .crc_valid      (crc_valid),
`endif
    .debug_state    (debug_state)
  );

  // Arbiter model: grant two cycles after request, ready always-on or alternating, done after H words
  initial begin
    int st;
    int wc;
    bit tg;
    st = 0; wc = 0; tg = 0;
    forever begin
      @(negedge clk_vga);
      sdram_wr_grant = 0;
      sdram_wr_done  = 0;
      sdram_wr_ready = 0;
      if (!rst_n) st = 0;
      else case (st)
        0: if (sdram_wr_req && hold_grant == 0) st = 1;
        1: begin sdram_wr_grant = 1; b_addr[nb] = sdram_wr_addr; st = 2; wc = 0; tg = 1; end
        2: if (wc == H) begin sdram_wr_done = 1; st = 3; end
           else begin
             sdram_wr_ready = (rdy_mode == 0) || tg;
             tg = ~tg;
             if (sdram_wr_ready) begin b_data[nb][wc] = sdram_wr_data; wc++; end
           end
        default: begin nb++; st = 0; end
      endcase
    end
  end

  // Count frame_done pulses (and capture the CRC shown with them)
  always @(negedge clk_vga) if (frame_done) begin
    fd_cnt++;
`ifdef VGA_LINE_WRITER_CRC_EN
    crc_v    = crc_valid;
    crc_seen = crc16;
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_vga);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int y, input int len, input int x, input bit cpx);
    return (x >= len) ? 16'h0000 : cpx ? 16'h1234 : {y[5:0], x[9:0]};
  endfunction

  task automatic start_frame();
    in_vs = 1; tick(2);
    in_vs = 0; tick(4);
  endtask

  task automatic send_line(input int y, input int len, input int gap, input bit cpx);
    for (int x = 0; x < len; x++) begin
      in_de = 1;
      in_pixel = cpx ? 16'h1234 : {y[5:0], x[9:0]};
      tick(1);
    end
    in_de = 0;
    in_pixel = 0;
    tick(gap);
  endtask

  task automatic wait_bursts(input string name, input int n);
    for (int i = 0; i < 2000 && nb < n; i++) tick(1);
    tick(60);
    chk(name, nb, n);
  endtask

  task automatic chk_burst(input int b, input int y, input int len, input logic [AW-1:0] base, input bit cpx);
    int bad;
    bad = -1;
    chk($sformatf("addr b%0d", b), b_addr[b], base + AW'(y * H));
    for (int x = 0; x < H; x++) if (bad < 0 && b_data[b][x] !== exp_word(y, len, x, cpx)) bad = x;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL data b%0d word %0d got %h want %h", b, bad, b_data[b][bad], exp_word(y, len, bad, cpx));
    end
  endtask

`ifdef VGA_LINE_WRITER_CRC_EN
  function automatic logic [15:0] crc_ref(input int n, input logic [15:0] w);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ w[b];
        c = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction
`endif

  initial begin
    checks = 0; errors = 0; nb = 0; fd_cnt = 0; hold_grant = 0; rdy_mode = 0;
    tbl = '{'{20, 1'b1, 1'b1}, '{16, 1'b0, 1'b0}, '{10, 1'b1, 1'b1}, '{16, 1'b1, 1'b1}, '{16, 1'b1, 1'b0}};
    tick(3);
    chk("rst req", sdram_wr_req, 0);
    chk("rst addr", sdram_wr_addr, 0);
    chk("rst data", sdram_wr_data, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst overflow", overflow, 0);
    chk("rst state", debug_state, 0);
    rst_n = 1; enable = 1; fb_base_addr = 24'h100000;
    tick(2);

    // Table frame: long line, disabled line, short line, normal line, line past V_ACTIVE
    start_frame();
    for (int i = 0; i < 5; i++) begin
      enable = tbl[i].en;
      send_line(i, tbl[i].len, 24, 0);
    end
    enable = 1;
    exp_n = 0;
    for (int i = 0; i < 5; i++) if (tbl[i].wr) exp_n++;
    wait_bursts("A bursts", exp_n);
    k = 0;
    for (int i = 0; i < 5; i++) if (tbl[i].wr) begin
      chk_burst(k, i, tbl[i].len, 24'h100000, 0);
      k++;
    end
    chk("A frame_done", fd_cnt, 1);
    chk("A overflow", overflow, 0);

    // Ready alternating during every burst
    nb = 0; fd_cnt = 0; rdy_mode = 1;
    start_frame();
    for (int i = 0; i < 4; i++) send_line(i, 16, 32, 0);
    wait_bursts("B bursts", 4);
    for (int i = 0; i < 4; i++) chk_burst(i, i, 16, 24'h100000, 0);
    chk("B frame_done", fd_cnt, 1);
    rdy_mode = 0;

    // Grant withheld: third line dropped, overflow sticky, later line written
    nb = 0; fd_cnt = 0; hold_grant = 1;
    start_frame();
    send_line(0, 16, 24, 0);
    send_line(1, 16, 24, 0);
    send_line(2, 16, 4, 0);
    chk("C overflow set", overflow, 1);
    chk("C no burst while held", nb, 0);
    hold_grant = 0;
    tick(40);
    send_line(3, 16, 4, 0);
    wait_bursts("C bursts", 3);
    chk_burst(0, 0, 16, 24'h100000, 0);
    chk_burst(1, 1, 16, 24'h100000, 0);
    chk_burst(2, 3, 16, 24'h100000, 0);
    chk("C frame_done", fd_cnt, 1);
    chk("C overflow sticky", overflow, 1);

    // Base address changed mid-frame applies only from the next frame
    nb = 0; fd_cnt = 0; fb_base_addr = 24'h000000;
    start_frame();
    send_line(0, 16, 24, 0);
    send_line(1, 16, 24, 0);
    fb_base_addr = 24'h200000;
    send_line(2, 16, 24, 0);
    send_line(3, 16, 24, 0);
    wait_bursts("D bursts", 4);
    for (int i = 0; i < 4; i++) chk_burst(i, i, 16, 24'h000000, 0);
    chk("D frame_done", fd_cnt, 1);
    nb = 0;
    start_frame();
    send_line(0, 16, 4, 0);
    wait_bursts("D next bursts", 1);
    chk_burst(0, 0, 16, 24'h200000, 0);

    // Reset in the middle of a burst, then a clean constant-pixel frame
    start_frame();
    send_line(0, 16, 2, 0);
    for (int i = 0; i < 50 && debug_state != 2'd2; i++) tick(1);
    chk("E reached burst", debug_state, 2);
    tick(4);
    rst_n = 0;
    #1;
    chk("E rst req", sdram_wr_req, 0);
    chk("E rst frame_done", frame_done, 0);
    chk("E rst overflow", overflow, 0);
    chk("E rst state", debug_state, 0);
    tick(2);
    rst_n = 1;
    tick(2);
    nb = 0; fd_cnt = 0;
    start_frame();
    for (int i = 0; i < 4; i++) send_line(i, 16, 24, 1);
    wait_bursts("E bursts", 4);
    for (int i = 0; i < 4; i++) chk_burst(i, i, 16, 24'h200000, 1);
    chk("E frame_done", fd_cnt, 1);
    chk("E overflow", overflow, 0);
`ifdef VGA_LINE_WRITER_CRC_EN
    chk("E crc_valid", crc_v, 1);
    chk("E crc16", crc_seen, crc_ref(4 * H, 16'h1234));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
